// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage and IF/ID register with PC, stall, flush and HLT freeze.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter int                 ADDR_W    = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [15:0]        NOP_INSTR = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_sig,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  output logic [15:0]       fd_instr,
  output logic [ADDR_W-1:0] fd_pc_plus2,
  output logic              fd_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt,
`endif
  output logic              halted
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_WAIT = 2'd1,
    HALTED    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       fd_instr_q, fd_instr_d;
  logic [ADDR_W-1:0] fd_pc_plus2_q, fd_pc_plus2_d;
  logic              fd_valid_q, fd_valid_d;
  logic [ADDR_W-1:0] pc_plus2;
  logic              fetch_load;
  logic              branch_acc;
  logic              stall_cnt_en;

  assign pc_plus2 = pc_q + ADDR_W'(2);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fd_instr_d    = fd_instr_q;
    fd_pc_plus2_d = fd_pc_plus2_q;
    fd_valid_d    = fd_valid_q;
    fetch_load    = 1'b0;
    branch_acc    = 1'b0;
    stall_cnt_en  = stall_sig && (state_q != HALTED);
    case (state_q)
      RUN, HALT_WAIT: begin
        if (!stall_sig) begin
          if (branch_taken) begin
            // A redirect also cancels a HALT_WAIT entered from a wrong-path HLT.
            branch_acc    = 1'b1;
            pc_d          = branch_target;
            fd_instr_d    = NOP_INSTR;
            fd_pc_plus2_d = '0;
            fd_valid_d    = 1'b0;
            state_d       = RUN;
          end else if (state_q == RUN) begin
            fetch_load    = 1'b1;
            fd_instr_d    = imem_data;
            fd_pc_plus2_d = pc_plus2;
            fd_valid_d    = 1'b1;
            if (imem_data[15:12] == 4'b1111) begin
              state_d = HALT_WAIT;
            end else begin
              pc_d = pc_plus2;
            end
          end else begin
            fd_instr_d    = NOP_INSTR;
            fd_pc_plus2_d = '0;
            fd_valid_d    = 1'b0;
            state_d       = HALTED;
          end
        end
      end
      default: begin
        state_d = HALTED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      fd_instr_q    <= NOP_INSTR;
      fd_pc_plus2_q <= '0;
      fd_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fd_instr_q    <= fd_instr_d;
      fd_pc_plus2_q <= fd_pc_plus2_d;
      fd_valid_q    <= fd_valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign fd_instr    = fd_instr_q;
  assign fd_pc_plus2 = fd_pc_plus2_q;
  assign fd_valid    = fd_valid_q;
  assign halted      = (state_q == HALTED);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
  logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;

  // Counters saturate rather than wrap.
  always_comb begin
    perf_fetch_cnt_d = perf_fetch_cnt_q;
    perf_stall_cnt_d = perf_stall_cnt_q;
    perf_flush_cnt_d = perf_flush_cnt_q;
    if (fetch_load && (perf_fetch_cnt_q != '1)) perf_fetch_cnt_d = perf_fetch_cnt_q + 32'd1;
    if (stall_cnt_en && (perf_stall_cnt_q != '1)) perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
    if (branch_acc && (perf_flush_cnt_q != '1)) perf_flush_cnt_d = perf_flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt_q <= '0;
      perf_stall_cnt_q <= '0;
      perf_flush_cnt_q <= '0;
    end else begin
      perf_fetch_cnt_q <= perf_fetch_cnt_d;
      perf_stall_cnt_q <= perf_stall_cnt_d;
      perf_flush_cnt_q <= perf_flush_cnt_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_cnt_q;
  assign perf_stall_cnt = perf_stall_cnt_q;
  assign perf_flush_cnt = perf_flush_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = fetch_load ^ branch_acc ^ stall_cnt_en;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with directed vectors.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_sig;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] fd_instr;
  logic [15:0] fd_pc_plus2;
  logic        fd_valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall_sig     (stall_sig),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .fd_instr      (fd_instr),
    .fd_pc_plus2   (fd_pc_plus2),
    .fd_valid      (fd_valid),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt),
`endif
    .halted        (halted)
  );

  always #5 clk = ~clk;

  // Word at byte address a holds 16'h1000 + (a>>1)[11:0]; HLT at 0x10 and 0x50.
  logic [15:0] mem [0:32767];
  assign imem_data = mem[imem_addr[15:1]];

  typedef struct {
    int          id;
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] p2;
    logic        chk_p2;
    logic        v;
    logic        h;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step_id = 0;

  task automatic step(input logic r, input logic s, input logic b, input logic [15:0] t,
                      input logic [15:0] e_pc, input logic [15:0] e_ins, input logic [15:0] e_p2,
                      input logic e_chk, input logic e_v, input logic e_h);
    exp_t e;
    rst = r; stall_sig = s; branch_taken = b; branch_target = t;
    @(posedge clk);
    e.id = step_id; e.pc = e_pc; e.instr = e_ins; e.p2 = e_p2;
    e.chk_p2 = e_chk; e.v = e_v; e.h = e_h;
    exp_q.push_back(e);
    step_id++;
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (imem_addr !== e.pc || fd_instr !== e.instr || fd_valid !== e.v || halted !== e.h ||
          (e.chk_p2 && fd_pc_plus2 !== e.p2)) begin
        n_bad++;
        $display("FAIL step%0d: got pc=%h instr=%h p2=%h v=%b h=%b, expected pc=%h instr=%h p2=%h(chk %b) v=%b h=%b",
                 e.id, imem_addr, fd_instr, fd_pc_plus2, fd_valid, halted,
                 e.pc, e.instr, e.p2, e.chk_p2, e.v, e.h);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'h1000 + {4'h0, i[11:0]};
    mem[16'h0008] = 16'hF000;
    mem[16'h0028] = 16'hF000;
    rst = 1'b1; stall_sig = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
    @(posedge clk); #1;
    //    rst   stall br    target      pc       instr     p2      chk   v     h
    step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, 16'h1000, 16'h0002, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, 16'h1001, 16'h0004, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0004, 16'h1001, 16'h0004, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0004, 16'h1001, 16'h0004, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0006, 16'h1002, 16'h0006, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0008, 16'h1003, 16'h0008, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h0040, 16'h0040, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    @(negedge clk);
    n_cmp++;
    if (perf_stall_cnt !== 32'd2 || perf_flush_cnt !== 32'd1 || perf_fetch_cnt !== 32'd4) begin
      n_bad++;
      $display("FAIL perf: got fetch=%0d stall=%0d flush=%0d, expected 4 2 1",
               perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt);
    end
    #1;
`endif
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0042, 16'h1020, 16'h0042, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'h0080, 16'h0042, 16'h1020, 16'h0042, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h0080, 16'h0080, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h000E, 16'h000E, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0010, 16'h1007, 16'h0010, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0010, 16'hF000, 16'h0012, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 16'h0020, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h0050, 16'h0050, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0050, 16'hF000, 16'h0052, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'hFFFE, 16'hFFFE, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1FFF, 16'h0000, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, 16'h1000, 16'h0002, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h0010, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0010, 16'hF000, 16'h0012, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0010, 16'hF000, 16'h0012, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0010, 16'hF000, 16'h0012, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    rst = 1'b0; stall_sig = 1'b0;
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
